// File: rtl/audio_receiver.sv
// Receive side of the audio link: validates Ethernet frames carrying stereo PCM
// and buffers their samples in a commit/rollback FIFO that is drained one pair per pcm_stb.
module audio_receiver #(
    parameter int unsigned HDR_LEN     = 14,
    parameter int unsigned PAYLOAD_LEN = 112,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int unsigned FIFO_AW     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               rx_sof,
    input  logic               rx_eof,
    input  logic               rx_good,
    input  logic               pcm_stb,
    output logic [15:0]        pcm_left,
    output logic [15:0]        pcm_right,
    output logic               pcm_valid,
    output logic               underrun,
    output logic [FIFO_AW:0]   fill,
    output logic [15:0]        frames_ok,
    output logic [15:0]        frames_drop
);

    localparam int unsigned BW    = 11;
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PAIRS = PAYLOAD_LEN / 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_TAIL,
        S_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            et_hi_ok_q, et_hi_ok_d;
    logic [15:0]     left_q, left_d;
    logic [7:0]      rlo_q, rlo_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   wr_commit_q, wr_commit_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [15:0]     frames_ok_q, frames_ok_d;
    logic [15:0]     frames_drop_q, frames_drop_d;
    logic [15:0]     pcm_left_q, pcm_right_q;
    logic            pcm_valid_q, underrun_q;

    logic            wr_en;
    logic [31:0]     wr_data;
    logic            rd_en;
    logic            ok_inc;
    logic [1:0]      drop_n;
    logic [PW-1:0]   free_space;
    logic [BW-1:0]   pay_idx;
    logic [16:0]     drop_sum;

    logic [31:0]     mem [DEPTH];

    // Frame parser, speculative writer and commit/rollback bookkeeping
    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        et_hi_ok_d    = et_hi_ok_q;
        left_d        = left_q;
        rlo_d         = rlo_q;
        wr_ptr_d      = wr_ptr_q;
        wr_commit_d   = wr_commit_q;
        wr_en         = 1'b0;
        wr_data       = '0;
        ok_inc        = 1'b0;
        drop_n        = 2'd0;
        free_space    = PW'(DEPTH) - (wr_ptr_q - rd_ptr_q);
        pay_idx       = bcnt_q - BW'(HDR_LEN);

        if (rx_valid) begin
            if (rx_sof) begin
                // A new start-of-frame aborts whatever frame is in flight
                if (state_q != S_IDLE) begin
                    wr_ptr_d = wr_commit_q;
                    drop_n   = 2'd1;
                end
                state_d    = S_HDR;
                bcnt_d     = BW'(1);
                et_hi_ok_d = 1'b0;
            end else begin
                case (state_q)
                    S_HDR: begin
                        bcnt_d = bcnt_q + BW'(1);
                        if (bcnt_q == BW'(HDR_LEN - 2))
                            et_hi_ok_d = (rx_data == ETHERTYPE[15:8]);
                        if (bcnt_q == BW'(HDR_LEN - 1)) begin
                            if (!et_hi_ok_q || rx_data != ETHERTYPE[7:0])
                                state_d = S_DROP;
                            else if (free_space < PW'(PAIRS))
                                state_d = S_DROP;
                            else
                                state_d = S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        bcnt_d = bcnt_q + BW'(1);
                        case (pay_idx[1:0])
                            2'd0: left_d[7:0]  = rx_data;
                            2'd1: left_d[15:8] = rx_data;
                            2'd2: rlo_d        = rx_data;
                            default: begin
                                wr_en    = 1'b1;
                                wr_data  = {left_q, rx_data, rlo_q};
                                wr_ptr_d = wr_ptr_q + PW'(1);
                            end
                        endcase
                        if (pay_idx == BW'(PAYLOAD_LEN - 1))
                            state_d = S_TAIL;
                    end
                    default: ;
                endcase
            end
        end

        // End of frame is judged against the state reached after this cycle's byte
        if (rx_eof && state_d != S_IDLE) begin
            if (state_d == S_TAIL && rx_good) begin
                wr_commit_d = wr_ptr_d;
                ok_inc      = 1'b1;
            end else begin
                wr_ptr_d = wr_commit_q;
                drop_n   = drop_n + 2'd1;
            end
            state_d = S_IDLE;
        end

        rd_en    = pcm_stb && (wr_commit_q != rd_ptr_q);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        fill_d   = wr_commit_d - rd_ptr_d;

        frames_ok_d = (ok_inc && frames_ok_q != 16'hFFFF) ? frames_ok_q + 16'd1 : frames_ok_q;
        drop_sum      = {1'b0, frames_drop_q} + 17'(drop_n);
        frames_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bcnt_q        <= '0;
            et_hi_ok_q    <= 1'b0;
            left_q        <= '0;
            rlo_q         <= '0;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            frames_ok_q   <= '0;
            frames_drop_q <= '0;
            pcm_left_q    <= '0;
            pcm_right_q   <= '0;
            pcm_valid_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            et_hi_ok_q    <= et_hi_ok_d;
            left_q        <= left_d;
            rlo_q         <= rlo_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            frames_ok_q   <= frames_ok_d;
            frames_drop_q <= frames_drop_d;
            pcm_valid_q   <= rd_en;
            underrun_q    <= pcm_stb && !rd_en;
            // Registered read port; an underrun zeroes the outputs instead
            if (rd_en)
                {pcm_left_q, pcm_right_q} <= mem[rd_ptr_q[FIFO_AW-1:0]];
            else if (pcm_stb)
                {pcm_left_q, pcm_right_q} <= '0;
        end
    end

    assign pcm_left    = pcm_left_q;
    assign pcm_right   = pcm_right_q;
    assign pcm_valid   = pcm_valid_q;
    assign underrun    = underrun_q;
    assign fill        = fill_q;
    assign frames_ok   = frames_ok_q;
    assign frames_drop = frames_drop_q;

endmodule

// File: tb/tb_audio_receiver.sv
// Bench for audio_receiver: random frames against a queue-based model of the
// committed sample stream; a monitor matches every pcm output against a scoreboard.
module tb_audio_receiver;

    localparam int DEPTH = 64;
    localparam int PAIRS = 28;
    localparam int PLEN  = 112;
    localparam int HLEN  = 14;

    logic        clk = 1'b0;
    logic        rst, rx_valid, rx_sof, rx_eof, rx_good, pcm_stb;
    logic [7:0]  rx_data;
    logic [15:0] pcm_left, pcm_right, frames_ok, frames_drop;
    logic        pcm_valid, underrun;
    logic [6:0]  fill;

    always #5 clk = ~clk;

    audio_receiver dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_good(rx_good), .pcm_stb(pcm_stb),
        .pcm_left(pcm_left), .pcm_right(pcm_right), .pcm_valid(pcm_valid),
        .underrun(underrun), .fill(fill), .frames_ok(frames_ok), .frames_drop(frames_drop)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mfifo[$];     // committed, not yet played {L,R}
    logic [32:0] exp_q[$];     // expected outputs: bit32 = underrun
    int          m_ok, m_drop;
    bit          open_frame;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One cycle of input; a strobe pops the model at the moment it is issued
    task automatic drive(input logic v, input logic [7:0] d, input logic sof,
                         input logic eof, input logic good, input logic stb);
        if (stb) begin
            if (mfifo.size() > 0) exp_q.push_back({1'b0, mfifo.pop_front()});
            else                  exp_q.push_back({1'b1, 32'h0});
        end
        rx_valid = v; rx_data = d; rx_sof = sof; rx_eof = eof; rx_good = good; pcm_stb = stb;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0; rx_eof = 1'b0;
        rx_good = 1'b0; pcm_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic send_frame(input logic [15:0] et, input int npay, input logic good,
                              input bit do_eof, input bit ramp, input bit stb_eof);
        logic [31:0] pairs[PAIRS];
        logic [31:0] w;
        logic [7:0]  b;
        bit          accept;
        int          ntail;
        for (int i = 0; i < PAIRS; i++)
            pairs[i] = ramp ? {16'(i), 16'(-i)} : $urandom;
        if (open_frame) m_drop++;
        open_frame = 1;
        accept = 0;
        for (int i = 0; i < HLEN; i++) begin
            b = 8'($urandom);
            if (i == 12) b = et[15:8];
            if (i == 13) begin
                b = et[7:0];
                accept = (et == 16'h88B5) && ((DEPTH - mfifo.size()) >= PAIRS);
            end
            drive(1'b1, b, (i == 0), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < npay; i++) begin
            w = pairs[i / 4];
            case (i % 4)
                0: b = w[23:16];
                1: b = w[31:24];
                2: b = w[7:0];
                default: b = w[15:8];
            endcase
            drive(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        if (!do_eof) return;
        ntail = (npay == PLEN) ? $urandom_range(4, 8) : 0;
        for (int i = 0; i < ntail - 1; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        if (ntail > 0 && $urandom_range(0, 1) == 1) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b1, good, stb_eof);
        end else begin
            if (ntail > 0) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 8'h00, 1'b0, 1'b1, good, stb_eof);
        end
        open_frame = 0;
        if (accept && npay == PLEN && good) begin
            for (int i = 0; i < PAIRS; i++) mfifo.push_back(pairs[i]);
            m_ok++;
        end else begin
            m_drop++;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_fill"}, 64'(fill), 64'(mfifo.size()));
        chk({tag, "_frames_ok"}, 64'(frames_ok), 64'(m_ok));
        chk({tag, "_frames_drop"}, 64'(frames_drop), 64'(m_drop));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        mfifo.delete();
        m_ok = 0; m_drop = 0; open_frame = 0;
        chk({tag, "_reset_outputs"},
            64'({pcm_left, pcm_right, pcm_valid, underrun, fill, frames_ok, frames_drop}), 64'd0);
    endtask

    // Scoreboard monitor, sampling on the inactive edge
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst === 1'b0 && (pcm_valid === 1'b1 || underrun === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pcm_output: valid=%b underrun=%b with nothing expected",
                         pcm_valid, underrun);
            end else begin
                e = exp_q.pop_front();
                chk("pcm_out", 64'({underrun, pcm_valid, pcm_left, pcm_right}),
                    e[32] ? 64'({2'b10, 32'h0}) : 64'({2'b01, e[31:0]}));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0;
        rx_eof = 1'b0; rx_good = 1'b0; pcm_stb = 1'b0;
        m_ok = 0; m_drop = 0; open_frame = 0;
        idle(1);
        do_reset("t1");

        // Ramp frame L=n, R=-n, then play it back in order
        send_frame(16'h88B5, PLEN, 1'b1, 1, 1, 0);
        check_state("t1_commit");
        play(PAIRS);
        check_state("t1_drained");

        // Bad FCS, then a good frame plays from its own first sample
        send_frame(16'h88B5, PLEN, 1'b0, 1, 1, 0);
        check_state("t2_badfcs");
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        check_state("t2_good");
        play(PAIRS);

        // Wrong EtherType
        send_frame(16'h0800, PLEN, 1'b1, 1, 0, 0);
        check_state("t3_ethertype");

        // Runt, then a frame aborted by a new start-of-frame
        send_frame(16'h88B5, 50, 1'b1, 1, 0, 0);
        check_state("t4_runt");
        send_frame(16'h88B5, 60, 1'b1, 0, 0, 0);
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        check_state("t4_abort");
        play(PAIRS);

        // Three frames without pops: the third has no room
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        check_state("t5_two");
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        check_state("t5_full");
        play(2 * PAIRS + 1);
        check_state("t5_underrun");

        // Commit on the same cycle as a pop with fill=5
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        play(PAIRS - 5);
        check_state("t6_fill5");
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 1);
        check_state("t6_commit_pop");
        play(32);

        // Reset mid-payload, then a fresh frame is accepted
        send_frame(16'h88B5, 40, 1'b1, 0, 0, 0);
        do_reset("t6_midreset");
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        check_state("t6_after_reset");
        play(PAIRS);

        // Randomized mix of frame types with interleaved playback
        for (int k = 0; k < 14; k++) begin
            logic [15:0] et;
            int          np;
            bit          g, eofb;
            et   = ($urandom_range(0, 4) == 0) ? 16'h0800 : 16'h88B5;
            g    = ($urandom_range(0, 5) != 0);
            np   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, PLEN - 1)) : PLEN;
            eofb = ($urandom_range(0, 6) != 0);
            send_frame(et, np, g, eofb, 0, 0);
            if (eofb) check_state("rand");
            play($urandom_range(0, 40));
        end
        send_frame(16'h88B5, PLEN, 1'b1, 1, 0, 0);
        check_state("rand_final");
        play(mfifo.size() + 1);
        idle(3);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
